gate_classifier: RTL and testbench

GATE_CLASSIFIER -- requirements
Module: gate_classifier

---
 rtl/gate_classifier_if.sv | 22 ++
 rtl/gate_classifier.sv | 144 ++++++++++++++
 tb/tb_gate_classifier.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gate_classifier_if.sv
// Request, result and probe signals between gate_classifier, its requester and the gate under test.
interface gate_classifier_if;
    logic       start;
    logic       probe_a;
    logic       probe_b;
    logic       probe_y;
    logic       busy;
    logic       done;
    logic [3:0] truth;
    logic [2:0] gate_code;
    logic       unstable;

    modport master (
        output start, probe_y,
        input  probe_a, probe_b, busy, done, truth, gate_code, unstable
    );

    modport slave (
        input  start, probe_y,
        output probe_a, probe_b, busy, done, truth, gate_code, unstable
    );
endinterface

// File: rtl/gate_classifier.sv
// Sweeps all four input vectors through a 2-input gate and classifies its truth table.
// Optional double-pass stability recheck: define GATE_CLASSIFIER_RECHECK_EN.
module gate_classifier #(
    parameter int unsigned SETTLE = 1
) (
    input logic              clk,
    input logic              rst,
    gate_classifier_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StDrive, StWait, StSample, StFinish} state_e;

    state_e     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic [3:0] shadow_q;
    logic       probe_a_q;
    logic       probe_b_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] truth_q;
    logic [2:0] gate_code_q;
    logic [3:0] sweep;

`ifdef GATE_CLASSIFIER_RECHECK_EN
    logic       pass_q;
    logic [3:0] first_q;
    logic       unstable_q;
`endif

    function automatic logic [2:0] decode(input logic [3:0] t);
        case (t)
            4'b1000: decode = 3'd0;
            4'b1110: decode = 3'd1;
            4'b0011: decode = 3'd2;
            4'b0111: decode = 3'd3;
            4'b0001: decode = 3'd4;
            4'b0110: decode = 3'd5;
            4'b1001: decode = 3'd6;
            default: decode = 3'd7;
        endcase
    endfunction

    // Complete pass result including the bit being captured on this edge.
    always_comb begin
        sweep        = shadow_q;
        sweep[idx_q] = bus.probe_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            shadow_q    <= 4'd0;
            probe_a_q   <= 1'b0;
            probe_b_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            truth_q     <= 4'd0;
            gate_code_q <= 3'd7;
`ifdef GATE_CLASSIFIER_RECHECK_EN
            pass_q      <= 1'b0;
            first_q     <= 4'd0;
            unstable_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q   <= StDrive;
                        idx_q     <= 2'd0;
                        probe_a_q <= 1'b0;
                        probe_b_q <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef GATE_CLASSIFIER_RECHECK_EN
                        pass_q    <= 1'b0;
`endif
                    end
                end
                StFinish: state_q <= StIdle;
                default: begin
                    if (state_q == StDrive && SETTLE >= 2) begin
                        state_q <= StWait;
                        cnt_q   <= 4'(SETTLE - 2);
                    end else if (state_q == StDrive && SETTLE == 1) begin
                        state_q <= StSample;
                    end else if (state_q == StWait) begin
                        if (cnt_q == 4'd0) state_q <= StSample;
                        else cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Last cycle of the drive window: capture and move on.
                        shadow_q[idx_q] <= bus.probe_y;
                        if (idx_q != 2'd3) begin
                            idx_q                  <= idx_q + 2'd1;
                            {probe_a_q, probe_b_q} <= idx_q + 2'd1;
                            state_q                <= StDrive;
                        end else begin
`ifdef GATE_CLASSIFIER_RECHECK_EN
                            if (!pass_q) begin
                                pass_q    <= 1'b1;
                                first_q   <= sweep;
                                idx_q     <= 2'd0;
                                probe_a_q <= 1'b0;
                                probe_b_q <= 1'b0;
                                state_q   <= StDrive;
                            end else begin
                                state_q     <= StFinish;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                probe_a_q   <= 1'b0;
                                probe_b_q   <= 1'b0;
                                truth_q     <= first_q;
                                unstable_q  <= (first_q != sweep);
                                gate_code_q <= (first_q != sweep) ? 3'd7 : decode(first_q);
                            end
`else
                            state_q     <= StFinish;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            probe_a_q   <= 1'b0;
                            probe_b_q   <= 1'b0;
                            truth_q     <= sweep;
                            gate_code_q <= decode(sweep);
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign bus.probe_a   = probe_a_q;
    assign bus.probe_b   = probe_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.truth     = truth_q;
    assign bus.gate_code = gate_code_q;
`ifdef GATE_CLASSIFIER_RECHECK_EN
    assign bus.unstable  = unstable_q;
`else
    assign bus.unstable  = 1'b0;
`endif
endmodule

// File: tb/tb_gate_classifier.sv
// Directed bench for gate_classifier (SETTLE=1) with a behavioural gate under test.
// Define GATE_CLASSIFIER_RECHECK_EN to exercise the double-pass build.
module tb_gate_classifier;
    localparam int unsigned SETTLE = 1;
`ifdef GATE_CLASSIFIER_RECHECK_EN
    localparam int BUSY_LEN = 8 * (SETTLE + 1);
`else
    localparam int BUSY_LEN = 4 * (SETTLE + 1);
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   gate_sel;
    logic [3:0] last_truth;
    logic [2:0] last_code;
    logic       last_unstable;

    gate_classifier_if bus ();

    gate_classifier #(.SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Gate under test: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 buffer b.
    always_comb begin
        case (gate_sel)
            0:       bus.probe_y = bus.probe_a & bus.probe_b;
            1:       bus.probe_y = bus.probe_a | bus.probe_b;
            2:       bus.probe_y = ~bus.probe_a;
            3:       bus.probe_y = ~(bus.probe_a & bus.probe_b);
            4:       bus.probe_y = ~(bus.probe_a | bus.probe_b);
            5:       bus.probe_y = bus.probe_a ^ bus.probe_b;
            6:       bus.probe_y = ~(bus.probe_a ^ bus.probe_b);
            default: bus.probe_y = bus.probe_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sweep from IDLE; gate switches from g1 to g2 halfway through the busy window.
    task automatic sweep(input string name, input int g1, input int g2,
                         input logic [3:0] exp_truth, input logic [2:0] exp_code,
                         input logic exp_unstable);
        gate_sel  = g1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < BUSY_LEN; c++) begin
            if (c == BUSY_LEN / 2) gate_sel = g2;
            check({name, " busy"}, 32'(bus.busy), 32'd1);
            check({name, " done_low"}, 32'(bus.done), 32'd0);
            check({name, " probe"}, 32'({bus.probe_a, bus.probe_b}),
                  32'((c / (SETTLE + 1)) % 4));
            check({name, " truth_hold"}, 32'(bus.truth), 32'(last_truth));
            check({name, " code_hold"}, 32'(bus.gate_code), 32'(last_code));
            check({name, " unstable_hold"}, 32'(bus.unstable), 32'(last_unstable));
            step();
        end
        check({name, " finish_busy"}, 32'(bus.busy), 32'd0);
        check({name, " finish_done"}, 32'(bus.done), 32'd1);
        check({name, " finish_probe"}, 32'({bus.probe_a, bus.probe_b}), 32'd0);
        check({name, " truth"}, 32'(bus.truth), 32'(exp_truth));
        check({name, " gate_code"}, 32'(bus.gate_code), 32'(exp_code));
        check({name, " unstable"}, 32'(bus.unstable), 32'(exp_unstable));
        step();
        check({name, " idle_done"}, 32'(bus.done), 32'd0);
        check({name, " idle_busy"}, 32'(bus.busy), 32'd0);
        check({name, " idle_truth"}, 32'(bus.truth), 32'(exp_truth));
        last_truth    = exp_truth;
        last_code     = exp_code;
        last_unstable = exp_unstable;
    endtask

    initial begin
        int n;
        int dones;
        rst           = 1'b1;
        bus.start     = 1'b0;
        gate_sel      = 0;
        last_truth    = 4'd0;
        last_code     = 3'd7;
        last_unstable = 1'b0;
        step();
        step();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst probe", 32'({bus.probe_a, bus.probe_b}), 32'd0);
        check("rst truth", 32'(bus.truth), 32'd0);
        check("rst gate_code", 32'(bus.gate_code), 32'd7);
        check("rst unstable", 32'(bus.unstable), 32'd0);
        rst = 1'b0;
        step();

        sweep("and", 0, 0, 4'b1000, 3'd0, 1'b0);
        sweep("xor", 5, 5, 4'b0110, 3'd5, 1'b0);
        sweep("nota", 2, 2, 4'b0011, 3'd2, 1'b0);
        sweep("buf", 7, 7, 4'b1010, 3'd7, 1'b0);
        sweep("nor", 4, 4, 4'b0001, 3'd4, 1'b0);
        sweep("or", 1, 1, 4'b1110, 3'd1, 1'b0);
        sweep("nand", 3, 3, 4'b0111, 3'd3, 1'b0);
        sweep("xnor", 6, 6, 4'b1001, 3'd6, 1'b0);

        // Abort on the 5th busy cycle, with start also high to test rst priority.
        gate_sel  = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        check("abort pre_busy", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort truth", 32'(bus.truth), 32'd0);
        check("abort gate_code", 32'(bus.gate_code), 32'd7);
        check("abort probe", 32'({bus.probe_a, bus.probe_b}), 32'd0);
        dones = 0;
        n     = 0;
        for (int c = 0; c < 2 * BUSY_LEN; c++) begin
            step();
            if (bus.done) dones++;
            if (bus.busy) n++;
        end
        check("abort no_done", 32'(dones), 32'd0);
        check("abort stays_idle", 32'(n), 32'd0);
        last_truth = 4'd0;
        last_code  = 3'd7;
        sweep("after_abort", 0, 0, 4'b1000, 3'd0, 1'b0);

        // start held high: back-to-back sweeps with one idle cycle between them.
        gate_sel  = 5;
        bus.start = 1'b1;
        step();
        for (int s = 0; s < 2; s++) begin
            n = 0;
            while (bus.busy && n <= BUSY_LEN + 4) begin
                n++;
                step();
            end
            check("held busy_len", 32'(n), 32'(BUSY_LEN));
            check("held done", 32'(bus.done), 32'd1);
            check("held truth", 32'(bus.truth), 32'b0110);
            check("held gate_code", 32'(bus.gate_code), 32'd5);
            step();
            check("held idle_gap", 32'(bus.busy), 32'd0);
            step();
            check("held restart", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        while (bus.busy && n < 4 * BUSY_LEN) begin
            n++;
            step();
        end
        step();
        step();
        check("held stop", 32'(bus.busy), 32'd0);
        last_truth    = 4'b0110;
        last_code     = 3'd5;
        last_unstable = 1'b0;

`ifdef GATE_CLASSIFIER_RECHECK_EN
        sweep("recheck_toggle", 1, 0, 4'b1110, 3'd7, 1'b1);
        sweep("recheck_stable", 0, 0, 4'b1000, 3'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
